// File: rtl/id_imm_pipe.sv
// rtl/id_imm_pipe.sv - immediate generation and pc-relative target with a 2-entry elastic output buffer
module id_imm_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_op
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_I    = 3'd1;
    localparam logic [2:0] OP_S    = 3'd2;
    localparam logic [2:0] OP_B    = 3'd3;
    localparam logic [2:0] OP_U    = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;
    localparam logic [2:0] OP_Z    = 3'd6;
    localparam logic [2:0] OP_SH   = 3'd7;

    logic [1:0]      count;
    logic [XLEN-1:0] imm_q [2];
    logic [XLEN-1:0] tgt_q [2];
    logic [XLEN-1:0] pc_q  [2];
    logic [2:0]      op_q  [2];

    logic            accept;
    logic            pop;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic signed [31:0] simm;
    logic            unused_inst;

    assign unused_inst = ^in_inst[6:0];

    // Signed forms are built at 32 bits and widened by a signed cast so the
    // same expressions serve both RV32 and RV64 without zero-width fills.
    always_comb begin
        simm = '0;
        imm  = '0;
        case (in_op)
            OP_NONE: imm = '0;
            OP_I: begin
                simm = {{20{in_inst[31]}}, in_inst[31:20]};
                imm  = XLEN'(simm);
            end
            OP_S: begin
                simm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                imm  = XLEN'(simm);
            end
            OP_B: begin
                simm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
                imm  = XLEN'(simm);
            end
            OP_U: begin
                simm = {in_inst[31:12], 12'b0};
                imm  = XLEN'(simm);
            end
            OP_J: begin
                simm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
                imm  = XLEN'(simm);
            end
            OP_Z:  imm = XLEN'(in_inst[19:15]);
            OP_SH: imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
            default: imm = '0;
        endcase
    end

    assign target   = in_pc + imm;
    assign in_ready = !rst && (count != 2'd2);
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;

    assign out_valid  = (count != 2'd0);
    assign out_imm    = imm_q[0];
    assign out_target = tgt_q[0];
    assign out_pc     = pc_q[0];
    assign out_op     = op_q[0];

    // Slot 0 is always the head; slot 1 shifts down on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tgt_q[i] <= '0;
                pc_q[i]  <= '0;
                op_q[i]  <= '0;
            end
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        imm_q[0] <= imm;
                        tgt_q[0] <= target;
                        pc_q[0]  <= in_pc;
                        op_q[0]  <= in_op;
                    end else begin
                        imm_q[1] <= imm;
                        tgt_q[1] <= target;
                        pc_q[1]  <= in_pc;
                        op_q[1]  <= in_op;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        imm_q[0] <= imm_q[1];
                        tgt_q[0] <= tgt_q[1];
                        pc_q[0]  <= pc_q[1];
                        op_q[0]  <= op_q[1];
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        imm_q[0] <= imm;
                        tgt_q[0] <= target;
                        pc_q[0]  <= in_pc;
                        op_q[0]  <= in_op;
                    end else begin
                        imm_q[0] <= imm_q[1];
                        tgt_q[0] <= tgt_q[1];
                        pc_q[0]  <= pc_q[1];
                        op_q[0]  <= op_q[1];
                        imm_q[1] <= imm;
                        tgt_q[1] <= target;
                        pc_q[1]  <= in_pc;
                        op_q[1]  <= in_op;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_imm_pipe.sv
// tb/tb_id_imm_pipe.sv - randomized and directed bench for id_imm_pipe at XLEN 32 and 64
module tb_id_imm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  op;

    logic        r32, v32, r64, v64;
    logic [31:0] imm32, tgt32, pco32;
    logic [63:0] imm64, tgt64, pco64;
    logic [2:0]  op32, op64;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] imm [2];
        logic [63:0] tgt [2];
        logic [63:0] pc;
        logic [2:0]  op;
    } entry_t;

    entry_t q[$];
    entry_t last;

    always #5 clk = ~clk;

    id_imm_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_inst(inst), .in_pc(pc[31:0]), .in_op(op), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_target(tgt32), .out_pc(pco32), .out_op(op32)
    );

    id_imm_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_inst(inst), .in_pc(pc), .in_op(op), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_target(tgt64), .out_pc(pco64), .out_op(op64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input longint x, input int n);
        longint half = longint'(1) <<< (n - 1);
        return (x >= half) ? x - (half <<< 1) : x;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] c, input int xlen);
        longint v;
        longint f31 = longint'(w >> 31);
        case (c)
            3'd1: v = sext(longint'(w >> 20), 12);
            3'd2: v = sext(longint'(((w >> 25) << 5) | ((w >> 7) & 31)), 12);
            3'd3: v = sext((f31 << 12) | (longint'((w >> 7) & 1) << 11)
                           | (longint'((w >> 25) & 63) << 5) | (longint'((w >> 8) & 15) << 1), 13);
            3'd4: v = sext(longint'(w & 32'hFFFFF000), 32);
            3'd5: v = sext((f31 << 20) | (longint'((w >> 12) & 255) << 12)
                           | (longint'((w >> 20) & 1) << 11) | (longint'((w >> 21) & 1023) << 1), 21);
            3'd6: v = longint'((w >> 15) & 31);
            3'd7: v = longint'((w >> 20) & ((xlen == 64) ? 63 : 31));
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic check_outputs();
        check_eq("v32", {63'd0, v32}, {63'd0, q.size() > 0});
        check_eq("v64", {63'd0, v64}, {63'd0, q.size() > 0});
        if (q.size() > 0) last = q[0];
        check_eq("imm32", {32'd0, imm32}, last.imm[0]);
        check_eq("tgt32", {32'd0, tgt32}, last.tgt[0]);
        check_eq("pc32",  {32'd0, pco32}, last.pc & 64'hFFFF_FFFF);
        check_eq("op32",  {61'd0, op32},  {61'd0, last.op});
        check_eq("imm64", imm64, last.imm[1]);
        check_eq("tgt64", tgt64, last.tgt[1]);
        check_eq("pc64",  pco64, last.pc);
        check_eq("op64",  {61'd0, op64}, {61'd0, last.op});
    endtask

    // One clock: check in_ready against the model, advance the model, check outputs.
    task automatic step();
        bit     exp_rdy, acc, pp;
        entry_t e;
        #1;
        exp_rdy = !rst && (q.size() < 2);
        check_eq("rdy32", {63'd0, r32}, {63'd0, exp_rdy});
        check_eq("rdy64", {63'd0, r64}, {63'd0, exp_rdy});
        acc = in_valid && exp_rdy && !flush;
        pp  = (q.size() > 0) && out_ready && !flush;
        e.imm[0] = ref_imm(inst, op, 32);
        e.imm[1] = ref_imm(inst, op, 64);
        e.tgt[0] = (pc + e.imm[0]) & 64'hFFFF_FFFF;
        e.tgt[1] = pc + e.imm[1];
        e.pc = pc;
        e.op = op;
        @(posedge clk);
        if (rst) begin
            q.delete();
            last = '{imm: '{64'd0, 64'd0}, tgt: '{64'd0, 64'd0}, pc: 64'd0, op: 3'd0};
        end else if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic offer(input logic [31:0] w, input logic [63:0] p, input logic [2:0] c);
        in_valid = 1'b1;
        inst = w;
        pc = p;
        op = c;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int vcount;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inst = '0; pc = '0; op = '0;
        last = '{imm: '{64'd0, 64'd0}, tgt: '{64'd0, 64'd0}, pc: 64'd0, op: 3'd0};
        step();
        step();
        rst = 1'b0;
        step();

        offer(32'hFFF00093, 64'h0, 3'd1);
        check_eq("I_imm", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        offer(32'h00112623, 64'h0, 3'd2);
        check_eq("S_imm", {32'd0, imm32}, 64'h0000_000C);
        offer(32'h000FD073, 64'h0, 3'd6);
        check_eq("Z_imm", {32'd0, imm32}, 64'h0000_001F);
        offer(32'hFE000EE3, 64'h100, 3'd3);
        check_eq("B_imm", {32'd0, imm32}, 64'hFFFF_FFFC);
        check_eq("B_tgt", {32'd0, tgt32}, 64'h0000_00FC);
        offer(32'h0010006F, 64'h1000, 3'd5);
        check_eq("J_imm", {32'd0, imm32}, 64'h800);
        check_eq("J_tgt", {32'd0, tgt32}, 64'h1800);
        offer(32'hFE000EE3, 64'h0, 3'd3);
        check_eq("B_wrap", {32'd0, tgt32}, 64'hFFFF_FFFC);
        offer(32'h800000B7, 64'h0, 3'd4);
        check_eq("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        offer(32'h03F01013, 64'h0, 3'd7);
        check_eq("SH_imm64", imm64, 64'h3F);
        check_eq("SH_imm32", {32'd0, imm32}, 64'h1F);
        step();

        // Backpressure: A and B fill the buffer, C waits until a slot frees.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst = 32'h00100093 + (i << 20);
            pc = 64'h2000 + 4 * i;
            op = 3'd1;
            if (i < 3) step();
        end
        inst = 32'h00300093; pc = 64'h2008;
        step();
        check_eq("bp_full_rdy", {63'd0, r32}, 64'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Streaming with out_ready high gives back-to-back valid cycles.
        vcount = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst = $urandom; op = 3'(i); pc = {$urandom, $urandom};
            step();
            vcount += int'(v32);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vcount += int'(v32);
        end
        check_eq("stream_valid", 64'(vcount), 64'd8);

        // Flush at count 2 alongside an offered entry.
        out_ready = 1'b0;
        offer(32'h12345013, 64'h40, 3'd1);
        offer(32'h23456013, 64'h44, 3'd2);
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", {63'd0, v32}, 64'd0);
        out_ready = 1'b1;
        step();

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            inst = $urandom;
            pc = {$urandom, $urandom};
            op = 3'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0; flush = 1'b0;

        // Reset in the middle of traffic.
        out_ready = 1'b0;
        offer(32'hFFF00093, 64'h80, 3'd1);
        offer(32'h0010006F, 64'h84, 3'd5);
        rst = 1'b1; in_valid = 1'b1;
        step();
        check_eq("rst_imm64", imm64, 64'd0);
        check_eq("rst_rdy64", {63'd0, r64}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_imm_pipe.md
# id_imm_pipe

Parametrised, pipelined immediate-generation stage for the decode path. It accepts a raw instruction word, its PC and an immediate-format code, and produces the XLEN-wide extended immediate plus the precomputed PC-relative target (pc + imm). Results leave through a 2-entry elastic buffer with valid/ready handshakes on both sides and a synchronous flush. The block sits between the fetch/decode register and the execute-stage operand mux, and supports both RV32 and RV64 datapaths.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous flush; discards all buffered entries.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  block can accept this cycle.
- in_inst  input  32  raw instruction word; only bits [31:7] are used.
- in_pc  input  XLEN  PC of the instruction.
- in_op  input  3  immediate format code (see Operation).
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_imm  output  XLEN  extended immediate.
- out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_pc  output  XLEN  PC carried with the entry.
- out_op  output  3  format code carried with the entry.

## Operation
- Format codes and immediate forms. "sx" means sign-extend from inst[31] to XLEN.
  - 0 NONE: 0.
  - 1 I: sx inst[31:20].
  - 2 S: sx {inst[31:25], inst[11:7]}.
  - 3 B: sx {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 4 U: sx {inst[31:12], 12'b0}. For XLEN=32 the top fill is empty.
  - 5 J: sx {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - 6 Z: zero-extend inst[19:15] (CSR uimm).
  - 7 SH: zero-extend inst[24:20] when XLEN=32; zero-extend inst[25:20] when XLEN=64.
- Target computation:
  - The target is computed at enqueue, as in_pc + imm, with XLEN-bit wraparound.
  - It is computed for every code; consumers ignore it where it is meaningless.
- Buffer:
  - 2-entry FIFO built from registered entries and a count register (0..2).
  - Entries are stored as imm, target, pc and op.
  - Outputs always drive the head entry.
- Accept: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- in_ready = !rst && (count < 2). It is combinational from state only and does not depend on out_ready. This avoids any ready path from out_ready to in_ready.
- Count rules:
  - Accept without pop: count+1.
  - Pop without accept: count−1.
  - Accept and pop together: count unchanged, FIFO order preserved.
- Full (count==2):
  - in_ready is 0.
  - A pop frees one slot, which becomes visible in the next cycle.
- Empty: out_valid is 0. out_imm, out_target, out_pc and out_op hold their last values; consumers must not rely on them.
- Flush:
  - Count goes to 0 at the next edge.
  - Any accept or pop in the same cycle is ignored.
  - Flush has priority below rst.
- Reset:
  - count = 0 and all entry registers = 0.
  - out_valid = 0, out_imm = out_target = out_pc = 0, out_op = 0.
  - in_ready = 0 while rst is high.
  - Reset asserted mid-operation discards all entries, exactly like flush.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N has out_valid=1 with its results from edge N to N+1.
- Throughput is one instruction per cycle while out_ready is held high.
- There is no combinational path from in_* to out_*. All outputs are registered.
- in_ready is low in the cycle rst is asserted. It first rises in the cycle after rst deasserts.
- Zero-bubble hand-off: with count==1 and both accept and pop in the same cycle, out_valid stays 1 and the next entry appears at the following edge.

## Test plan
- I/S/Z decode, XLEN=32:
  - inst 0xFFF00093, op=1 → imm 0xFFFFFFFF.
  - inst 0x00112623, op=2 → imm 0x0000000C.
  - inst 0x000FD073, op=6 → imm 0x0000001F.
  - Each result is valid 1 cycle after accept.
- Branch/jump targets, XLEN=32:
  - inst 0xFE000EE3, op=3, pc 0x100 → imm 0xFFFFFFFC, target 0x000000FC.
  - inst 0x0010006F, op=5, pc 0x1000 → imm 0x800, target 0x1800.
  - inst 0xFE000EE3, op=3, pc 0x0 → target 0xFFFFFFFC (wrap).
- XLEN=64:
  - inst 0x800000B7, op=4 → imm 0xFFFFFFFF80000000.
  - inst 0x03F01013, op=7 → imm 0x3F.
  - The same SH instruction with XLEN=32 → imm 0x1F.
- Backpressure:
  - Hold out_ready=0 and offer A, B, C back-to-back.
  - A and B are accepted, in_ready=0 after 2 accepts, and C is held.
  - Release out_ready → order A, B, C with no loss or duplication.
- Simultaneous accept and pop at count==1 → count stays 1. Streaming 8 instructions with out_ready=1 → 8 consecutive out_valid cycles.
- Flush and reset:
  - With count==2, assert flush together with in_valid → next cycle out_valid=0, count=0, and the offered entry is dropped.
  - Assert rst mid-stream → all outputs 0 and in_ready=0 during rst.
